// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - multi-cycle radix-2 restoring divider (DIV/DIVU), start/busy/done handshake
// Optional macro DIV_ZERO_FLAG_EN adds the registered div_zero output.
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             aclr_n,
  input  logic             clken,
  input  logic             start,
  input  logic             abort,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] numer,
  input  logic [WIDTH-1:0] denom,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remain
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic             div_zero
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] numer_l;
  logic             q_neg;
  logic             r_neg;
  logic             dz_op;

  logic             n_neg;
  logic             d_neg;
  logic [WIDTH-1:0] n_mag;
  logic [WIDTH-1:0] d_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  always_comb begin
    n_neg  = is_signed & numer[WIDTH-1];
    d_neg  = is_signed & denom[WIDTH-1];
    n_mag  = n_neg ? -numer : numer;
    d_mag  = d_neg ? -denom : denom;
    // The dividend shifts out of q_sh into the partial remainder one bit per step.
    rem_sh = {rem, q_sh[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs};
    q_fin  = q_neg ? -q_sh : q_sh;
    r_fin  = r_neg ? -rem : rem;
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state    <= IDLE;
      count    <= '0;
      rem      <= '0;
      q_sh     <= '0;
      dvs      <= '0;
      numer_l  <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      dz_op    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quotient <= '0;
      remain   <= '0;
`ifdef DIV_ZERO_FLAG_EN
      div_zero <= 1'b0;
`endif
    end else if (clken) begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              q_sh    <= n_mag;
              dvs     <= d_mag;
              rem     <= '0;
              numer_l <= numer;
              q_neg   <= n_neg ^ d_neg;
              r_neg   <= n_neg;
              dz_op   <= (denom == '0);
              count   <= CW'(WIDTH);
              busy    <= 1'b1;
              state   <= CALC;
            end
          end
          CALC: begin
            q_sh  <= {q_sh[WIDTH-2:0], ~diff[WIDTH]};
            rem   <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
            count <= count - CW'(1);
            if (count == CW'(1)) state <= FINISH;
          end
          FINISH: begin
            // Divide-by-zero results are fixed by the ISA, not taken from the datapath.
            quotient <= dz_op ? '1 : q_fin;
            remain   <= dz_op ? numer_l : r_fin;
`ifdef DIV_ZERO_FLAG_EN
            div_zero <= dz_op;
`endif
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// tb/tb_iter_divider.sv - directed vector bench for iter_divider (WIDTH=32)
module tb_iter_divider;

  logic        clock = 1'b0;
  logic        aclr_n = 1'b0;
  logic        clken = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] numer = '0;
  logic [31:0] denom = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remain;
`ifdef DIV_ZERO_FLAG_EN
  logic        div_zero;
`endif

  int n_checks = 0;
  int n_fail = 0;

  iter_divider #(.WIDTH(32)) dut (
    .clock(clock), .aclr_n(aclr_n), .clken(clken), .start(start), .abort(abort),
    .is_signed(is_signed), .numer(numer), .denom(denom), .busy(busy), .done(done),
    .quotient(quotient), .remain(remain)
`ifdef DIV_ZERO_FLAG_EN
    , .div_zero(div_zero)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        sgn;
    logic [31:0] n;
    logic [31:0] d;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
    logic        exp_dz;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_div(input logic s, input logic [31:0] n, input logic [31:0] d,
                         output int lat, output int bcnt);
    @(negedge clock);
    start = 1'b1; is_signed = s; numer = n; denom = d;
    lat = 0; bcnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      start = 1'b0;
      lat++;
      if (busy) bcnt++;
      if (done) break;
    end
  endtask

  initial begin
    int lat, bcnt, cyc;

    vecs[0]  = '{1'b0, 32'd100,       32'd7,        32'd14,       32'd2,        1'b0};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{1'b1, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0};
    vecs[3]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0};
    vecs[4]  = '{1'b0, 32'h80000000,  32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
    vecs[5]  = '{1'b0, 32'h1234,      32'd0,        32'hFFFFFFFF, 32'h1234,     1'b1};
    vecs[6]  = '{1'b1, 32'hFFFFFFFB,  32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1};
    vecs[7]  = '{1'b0, 32'hFFFFFFFF,  32'd1,        32'hFFFFFFFF, 32'd0,        1'b0};
    vecs[8]  = '{1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0};
    vecs[9]  = '{1'b0, 32'd9,         32'd3,        32'd3,        32'd0,        1'b0};
    vecs[10] = '{1'b0, 32'd5,         32'd10,       32'd0,        32'd5,        1'b0};
    vecs[11] = '{1'b1, 32'h80000000,  32'd1,        32'h80000000, 32'd0,        1'b0};
    vecs[12] = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b0};
    vecs[13] = '{1'b1, 32'd100,       32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0};

    repeat (3) @(negedge clock);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset quotient", quotient, 32'd0);
    check("reset remain", remain, 32'd0);
`ifdef DIV_ZERO_FLAG_EN
    check("reset div_zero", {31'd0, div_zero}, 32'd0);
`endif
    aclr_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_div(vecs[i].sgn, vecs[i].n, vecs[i].d, lat, bcnt);
      check($sformatf("vec%0d latency", i), lat, 32'd34);
      check($sformatf("vec%0d busy cycles", i), bcnt, 32'd33);
      check($sformatf("vec%0d quotient", i), quotient, vecs[i].exp_q);
      check($sformatf("vec%0d remain", i), remain, vecs[i].exp_r);
`ifdef DIV_ZERO_FLAG_EN
      check($sformatf("vec%0d div_zero", i), {31'd0, div_zero}, {31'd0, vecs[i].exp_dz});
`endif
    end

    // clken stall of 5 edges mid-CALC, plus an ignored start while busy
    @(negedge clock);
    start = 1'b1; is_signed = 1'b0; numer = 32'd1000; denom = 32'd10;
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      cyc++;
      if (done) break;
      start = (cyc == 3);
      if (cyc == 3) begin numer = 32'd50; denom = 32'd5; end
      clken = !(cyc >= 6 && cyc < 11);
    end
    clken = 1'b1; start = 1'b0;
    check("stall latency", cyc, 32'd39);
    check("stall quotient", quotient, 32'd100);
    check("stall remain", remain, 32'd0);

    // abort 3 cycles after start, then an immediate new start
    @(negedge clock);
    start = 1'b1; numer = 32'd77; denom = 32'd5;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    @(negedge clock); abort = 1'b1;
    @(negedge clock); abort = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort quotient held", quotient, 32'd100);
    check("abort remain held", remain, 32'd0);
    start = 1'b1; numer = 32'd9; denom = 32'd3;
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      start = 1'b0;
      lat++;
      if (done) break;
    end
    check("post-abort latency", lat, 32'd34);
    check("post-abort quotient", quotient, 32'd3);
    check("post-abort remain", remain, 32'd0);

    // abort beats start in the same cycle
    @(negedge clock);
    start = 1'b1; abort = 1'b1; numer = 32'd8; denom = 32'd2;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    check("abort over start busy", {31'd0, busy}, 32'd0);

    // async reset mid-CALC
    @(negedge clock);
    start = 1'b1; numer = 32'd77; denom = 32'd5;
    @(negedge clock); start = 1'b0;
    repeat (10) @(negedge clock);
    aclr_n = 1'b0;
    #1;
    check("mid reset busy", {31'd0, busy}, 32'd0);
    check("mid reset done", {31'd0, done}, 32'd0);
    check("mid reset quotient", quotient, 32'd0);
    check("mid reset remain", remain, 32'd0);
    @(negedge clock);
    aclr_n = 1'b1;
    run_div(1'b0, 32'd100, 32'd7, lat, bcnt);
    check("after reset latency", lat, 32'd34);
    check("after reset quotient", quotient, 32'd14);
    check("after reset remain", remain, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
